// File: rtl/serial_cmp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : serial_cmp_pkg
// Brief  : Shared constants for the serial magnitude comparator: FSM state
//          encoding, result codes, maximum operand width and a result decoder.
// Rev    : 1.0  initial release
// ============================================================================
package serial_cmp_pkg;

  // Largest operand width the comparator is built for.
  localparam int WIDTH_MAX = 32;

  // FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

  // Compare result codes.
  typedef logic [1:0] res_t;
  localparam res_t RES_EQ = 2'd0;
  localparam res_t RES_GT = 2'd1;
  localparam res_t RES_LT = 2'd2;

  // Decode a result code into one-hot {eq, gt, lt} flags.
  function automatic logic [2:0] res_flags(input res_t r);
    logic [2:0] f;
    f = 3'b100;
    case (r)
      RES_GT:  f = 3'b010;
      RES_LT:  f = 3'b001;
      default: f = 3'b100;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_bit_cell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : cmp_bit_cell
// Brief  : Single-bit unsigned compare cell producing one-hot eq/gt/lt.
// Rev    : 1.0  initial release
// ============================================================================
module cmp_bit_cell (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic gt,
  output logic lt
);

  assign eq = (a == b);
  assign gt = a & ~b;
  assign lt = ~a & b;

endmodule
`default_nettype wire

// File: rtl/serial_mag_compare.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : serial_mag_compare
// Brief  : Bit-serial unsigned magnitude comparator. Operands are captured on
//          an accepted start, walked MSB-first through one compare cell, and
//          the registered eq/gt/lt result is announced with a done pulse.
//          Build option SERIAL_CMP_EARLY_EXIT_EN: when defined the walk stops
//          at the first differing bit; when undefined all WIDTH bits are
//          always walked for a fixed latency, with the first difference
//          remembered.
// Rev    : 1.0  initial release
// ============================================================================
module serial_mag_compare
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8  // operand width, 2..WIDTH_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               eq_q;
  logic               gt_q;
  logic               lt_q;

  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic               w_decide;
  logic               w_bit_eq;
  logic               w_bit_gt;
  logic               w_bit_lt;
  res_t               w_bit_res;
  res_t               w_res;

  // The single compare cell always looks at the current MSB pair.
  cmp_bit_cell u_cell (
    .a  (a_q[WIDTH-1]),
    .b  (b_q[WIDTH-1]),
    .eq (w_bit_eq),
    .gt (w_bit_gt),
    .lt (w_bit_lt)
  );

  assign w_bit_res = w_bit_gt ? RES_GT : (w_bit_lt ? RES_LT : RES_EQ);
  assign w_last    = (cnt_q == '0);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  // Stop on the first differing bit, or on the final bit when all matched.
  assign w_decide = !w_bit_eq || w_last;
  assign w_res    = w_bit_res;
`else
  logic found_q;
  res_t first_q;

  // Remember the verdict of the first differing bit while the walk continues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found_q <= 1'b0;
      first_q <= RES_EQ;
    end else if (w_load) begin
      found_q <= 1'b0;
      first_q <= RES_EQ;
    end else if (w_step && !found_q && !w_bit_eq) begin
      found_q <= 1'b1;
      first_q <= w_bit_res;
    end
  end

  // Fixed latency: always decide on the last bit; an earlier difference wins.
  assign w_decide = w_last;
  assign w_res    = found_q ? first_q : w_bit_res;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (w_decide) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: status flags and datapath enables decoded from the state.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    w_load = 1'b0;
    w_step = 1'b0;
    case (state_q)
      IDLE:    w_load = start;
      SHIFT: begin
        busy   = 1'b1;
        w_step = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operand shift registers and non-wrapping bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (w_load) begin
      a_q   <= a;
      b_q   <= b;
      cnt_q <= CNT_W'(WIDTH - 1);
    end else if (w_step) begin
      a_q <= {a_q[WIDTH-2:0], 1'b0};
      b_q <= {b_q[WIDTH-2:0], 1'b0};
      if (!w_last) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Result flags change only on the decision edge and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_q <= 1'b0;
      gt_q <= 1'b0;
      lt_q <= 1'b0;
    end else if (w_step && w_decide) begin
      {eq_q, gt_q, lt_q} <= res_flags(w_res);
    end
  end

  assign eq = eq_q;
  assign gt = gt_q;
  assign lt = lt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_compare.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_serial_mag_compare
// Brief  : Scoreboard bench for serial_mag_compare (WIDTH=8). Stimulus pushes
//          expected {eq,gt,lt}, latency and start cycle; a monitor pops on each
//          done pulse and also watches that flags hold between results.
// Rev    : 1.0  initial release
// ============================================================================
module tb_serial_mag_compare;

  localparam int W = 8;

  typedef struct {
    logic [2:0] flags;      // {eq, gt, lt}
    int         start_cyc;  // cycle number of the accepting edge
    int         lat;        // cycles from start edge to done
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         eq;
  logic         gt;
  logic         lt;

  int           cyc;
  int           n_checks;
  int           n_err;
  int           busy_run;
  logic [2:0]   last_flags;
  exp_t         exp_q[$];

  serial_mag_compare #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned comparison.
  function automatic logic [2:0] model_flags(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x == y) return 3'b100;
    if (x > y)  return 3'b010;
    return 3'b001;
  endfunction

  // Reference latency: position of first differing bit counted from the MSB.
  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    logic [W-1:0] d;
    d = x ^ y;
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i]) return W - i;
    end
    return W;
`else
    return W;
`endif
  endfunction

  // Monitor: pop and compare on every done; otherwise flags must hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run   = 0;
      last_flags = 3'b000;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("flags", int'({eq, gt, lt}), int'(e.flags));
          check("latency", cyc - e.start_cyc, e.lat);
          check("busy_cycles", busy_run, e.lat);
          check("busy_at_done", int'(busy), 0);
          last_flags = e.flags;
        end
        busy_run = 0;
      end else begin
        check("flags_hold", int'({eq, gt, lt}), int'(last_flags));
      end
    end
  end

  // Wait (bounded) for the negedge where done is high.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < W + 6 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  // One compare; caller guarantees the next negedge is an IDLE cycle.
  task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb);
    exp_t e;
    @(negedge clk);
    a     = ta;
    b     = tb;
    start = 1'b1;
    e.flags     = model_flags(ta, tb);
    e.lat       = model_lat(ta, tb);
    e.start_cyc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    wait_done();
  endtask

  initial begin
    exp_t e;
    int   s0;
    int   per;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    n_checks   = 0;
    n_err      = 0;
    busy_run   = 0;
    last_flags = 3'b000;
    rst_n      = 1'b0;
    start      = 1'b0;
    a          = '0;
    b          = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_flags", int'({eq, gt, lt}), 0);
    rst_n = 1'b1;

    // Directed vectors: equal, MSB difference, LSB difference.
    run(8'hA5, 8'hA5);
    run(8'h80, 8'h7F);
    run(8'h12, 8'h13);

    // Start pulsed mid-compare must be ignored.
    @(negedge clk);
    a     = 8'h01;
    b     = 8'h02;
    start = 1'b1;
    e.flags     = model_flags(8'h01, 8'h02);
    e.lat       = model_lat(8'h01, 8'h02);
    e.start_cyc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (W + 4) @(negedge clk);

    // Reset mid-compare aborts with no done; flags cleared at once.
    @(negedge clk);
    a     = 8'h10;
    b     = 8'h20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_flags", int'({eq, gt, lt}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(8'h20, 8'h10);

    // Start held high: a new compare every lat+2 cycles.
    @(negedge clk);
    a     = 8'h40;
    b     = 8'h40;
    start = 1'b1;
    s0    = cyc + 1;
    per   = model_lat(8'h40, 8'h40) + 2;
    for (int k = 0; k < 3; k++) begin
      e.flags     = model_flags(8'h40, 8'h40);
      e.lat       = model_lat(8'h40, 8'h40);
      e.start_cyc = s0 + k * per;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 3 * per + 5 && cyc < s0 + 2 * per; i++) @(negedge clk);
    start = 1'b0;
    wait_done();

    // Randomized operands, biased toward equal and single-bit differences.
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ 8'(1 << $urandom_range(0, W - 1));
        default: rb = 8'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run(ra, rb);
    end

    repeat (W + 4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
